// File: rtl/cla_down_counter.sv
// cla_down_counter: loadable down-counter with nibble borrow-lookahead decrement, cascade borrow, zero flag and done pulse
module cla_down_counter #(
  parameter int WIDTH = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow_out,
  output logic             done
);
  localparam int G = WIDTH / 4;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_down_counter: WIDTH must be a positive multiple of 4");
  end
  logic [WIDTH-1:0] p, b, dec, reload_reg;
  logic [G-1:0] gp, gb;
  assign p = ~count;
  for (genvar g = 0; g < G; g++) begin : g_grp
    assign gp[g] = &p[4*g +: 4];
    if (g == 0) begin : g_first
      assign gb[g] = 1'b1;
    end else begin : g_rest
      assign gb[g] = &gp[g-1:0];
    end
    assign b[4*g]   = gb[g];
    assign b[4*g+1] = gb[g] & p[4*g];
    assign b[4*g+2] = gb[g] & p[4*g] & p[4*g+1];
    assign b[4*g+3] = gb[g] & p[4*g] & p[4*g+1] & p[4*g+2];
  end
  assign dec        = count ^ b;
  assign zero       = count == '0;
  assign borrow_out = en & ~load & zero;
  // count/reload/done update: rst > load > en > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else if (load) begin
      count      <= load_val;
      reload_reg <= load_val;
      done       <= 1'b0;
    end else if (en) begin
      count <= zero ? ((AUTO_RELOAD != 0) ? reload_reg : '1) : dec;
      done  <= count == WIDTH'(1);
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cla_down_counter.sv
// tb_cla_down_counter: directed checks of wrap, auto-reload, priority, lookahead boundaries and cascade
module tb_cla_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load0 = 1'b0, en0 = 1'b0, load1 = 1'b0, en1 = 1'b0, cl = 1'b0, ce = 1'b0;
  logic [7:0] val0 = '0;
  logic [3:0] lv = '0, hv = '0;
  logic [7:0] c0, c1;
  logic z0, b0, d0, z1, b1, d1;
  logic [3:0] clo, chi;
  logic zlo, blo, dlo, zhi, bhi, dhi;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  cla_down_counter #(.WIDTH(8), .AUTO_RELOAD(0)) u0 (.clk(clk), .rst(rst), .load(load0), .load_val(val0), .en(en0),
    .count(c0), .zero(z0), .borrow_out(b0), .done(d0));
  cla_down_counter #(.WIDTH(8), .AUTO_RELOAD(1)) u1 (.clk(clk), .rst(rst), .load(load1), .load_val(val0), .en(en1),
    .count(c1), .zero(z1), .borrow_out(b1), .done(d1));
  cla_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) u_lo (.clk(clk), .rst(rst), .load(cl), .load_val(lv), .en(ce),
    .count(clo), .zero(zlo), .borrow_out(blo), .done(dlo));
  cla_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) u_hi (.clk(clk), .rst(rst), .load(cl), .load_val(hv), .en(blo),
    .count(chi), .zero(zhi), .borrow_out(bhi), .done(dhi));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld0(input logic [7:0] v);
    load0 = 1'b1; val0 = v; en0 = 1'b0;
    tick();
    load0 = 1'b0;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", c0, 0);
    chk("rst_zero", z0, 1);
    chk("rst_done", d0, 0);
    chk("rst_borrow_idle", b0, 0);
    en0 = 1'b1; #1;
    chk("rst_borrow_en", b0, 1);
    en0 = 1'b0;

    ld0(8'h03);
    chk("ld03", c0, 8'h03);
    en0 = 1'b1; #1;
    chk("seq_b03", b0, 0);
    tick(); chk("seq02", c0, 8'h02); chk("seq_d02", d0, 0); chk("seq_b02", b0, 0);
    tick(); chk("seq01", c0, 8'h01); chk("seq_d01", d0, 0);
    tick(); chk("seq00", c0, 8'h00); chk("seq_d00", d0, 1); chk("seq_b00", b0, 1); chk("seq_z00", z0, 1);
    tick(); chk("seqFF", c0, 8'hFF); chk("seq_dFF", d0, 0); chk("seq_bFF", b0, 0);
    en0 = 1'b0;
    tick(); chk("hold_FF", c0, 8'hFF); chk("hold_done", d0, 0);

    ld0(8'h10); en0 = 1'b1; tick(); en0 = 1'b0; chk("b10", c0, 8'h0F);
    ld0(8'h00); en0 = 1'b1; tick(); en0 = 1'b0; chk("b00", c0, 8'hFF);
    ld0(8'h80); en0 = 1'b1; tick(); en0 = 1'b0; chk("b80", c0, 8'h7F);

    for (int v = 0; v < 256; v++) begin
      ld0(8'(v)); en0 = 1'b1; tick(); en0 = 1'b0;
      chk($sformatf("sweep%0h", v), c0, (v == 0) ? 8'hFF : 8'(v - 1));
    end

    ld0(8'h05);
    load0 = 1'b1; en0 = 1'b1; val0 = 8'h30; #1;
    chk("pri_b_load", b0, 0);
    tick(); load0 = 1'b0; en0 = 1'b0;
    chk("pri_load30", c0, 8'h30);
    ld0(8'h00);
    load0 = 1'b1; en0 = 1'b1; val0 = 8'h5A; #1;
    chk("pri_b_zero", b0, 0);
    tick(); load0 = 1'b0; en0 = 1'b0;
    chk("pri_load5A", c0, 8'h5A);
    rst = 1'b1; load0 = 1'b1; val0 = 8'h77;
    tick(); rst = 1'b0; load0 = 1'b0;
    chk("pri_rst", c0, 0);
    chk("pri_rst_done", d0, 0);

    load1 = 1'b1; val0 = 8'h02; tick(); load1 = 1'b0;
    chk("ar02", c1, 8'h02);
    en1 = 1'b1;
    tick(); chk("ar01", c1, 8'h01); chk("ar_d01", d1, 0);
    tick(); chk("ar00", c1, 8'h00); chk("ar_d00", d1, 1); chk("ar_b00", b1, 1);
    tick(); chk("ar_rl02", c1, 8'h02); chk("ar_d_rl", d1, 0);
    tick(); chk("ar01b", c1, 8'h01);
    tick(); chk("ar00b", c1, 8'h00); chk("ar_d00b", d1, 1);
    en1 = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    en1 = 1'b1;
    tick(); chk("ar_zero_stay", c1, 0); chk("ar_zero_b", b1, 1);
    tick(); chk("ar_zero_stay2", c1, 0); chk("ar_zero_d", d1, 0);
    en1 = 1'b0;

    cl = 1'b1; lv = 4'h0; hv = 4'h2; tick(); cl = 1'b0;
    chk("cas_init", {chi, clo}, 8'h20);
    ce = 1'b1; #1;
    chk("cas_blo", blo, 1);
    tick(); ce = 1'b0;
    chk("cas_lo", clo, 4'hF);
    chk("cas_hi", chi, 4'h1);
    chk("cas_comb", {chi, clo}, 8'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
